// File: rtl/mem_stage_lsu.sv
// Memory stage: drives the data bus for loads/stores, aligns load data and
// registers the write-back bundle. Non-memory ops pass through in one cycle.
module mem_stage_lsu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [4:0]            rd_addr_i,
    input  logic [1:0]            result_src_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  wb_valid_o,
    output logic [4:0]            wb_rd_addr_o,
    output logic [1:0]            wb_result_src_o,
    output logic [DATA_WIDTH-1:0] wb_alu_result_o,
    output logic [DATA_WIDTH-1:0] wb_mem_rdata_o,
    output logic [DATA_WIDTH-1:0] wb_pc_o,
    output logic                  misaligned_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                state;
    logic                  l_store;
    logic [2:0]            l_funct3;
    logic [DATA_WIDTH-1:0] l_alu;
    logic [DATA_WIDTH-1:0] l_pc;
    logic [4:0]            l_rd;
    logic [1:0]            l_src;

    logic                  is_mem;
    logic                  misaligned;
    logic [3:0]            be_in;
    logic [DATA_WIDTH-1:0] wdata_lanes;
    logic [DATA_WIDTH-1:0] rdata_shifted;
    logic [DATA_WIDTH-1:0] load_data;

    assign req_ready_o = (state == IDLE);
    assign is_mem      = mem_read_i | mem_write_i;

    // Replicating the store data fills every lane, so the byte enables alone pick the target.
    always_comb begin
        be_in       = 4'b1111;
        wdata_lanes = wdata_i;
        misaligned  = 1'b0;
        case (funct3_i)
            3'b000, 3'b100: begin
                be_in       = 4'b0001 << alu_result_i[1:0];
                wdata_lanes = {4{wdata_i[7:0]}};
            end
            3'b001, 3'b101: begin
                be_in       = 4'b0011 << alu_result_i[1:0];
                wdata_lanes = {2{wdata_i[15:0]}};
                misaligned  = alu_result_i[0];
            end
            default: begin
                be_in       = 4'b1111;
                wdata_lanes = wdata_i;
                misaligned  = |alu_result_i[1:0];
            end
        endcase
    end

    always_comb begin
        rdata_shifted = dmem_rdata_i >> {l_alu[1:0], 3'b000};
        case (l_funct3)
            3'b000:  load_data = {{(DATA_WIDTH-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{(DATA_WIDTH-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, rdata_shifted[15:0]};
            default: load_data = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            l_store         <= 1'b0;
            l_funct3        <= '0;
            l_alu           <= '0;
            l_pc            <= '0;
            l_rd            <= '0;
            l_src           <= '0;
            dmem_req_o      <= 1'b0;
            dmem_we_o       <= 1'b0;
            dmem_addr_o     <= '0;
            dmem_be_o       <= '0;
            dmem_wdata_o    <= '0;
            wb_valid_o      <= 1'b0;
            wb_rd_addr_o    <= '0;
            wb_result_src_o <= '0;
            wb_alu_result_o <= '0;
            wb_mem_rdata_o  <= '0;
            wb_pc_o         <= '0;
            misaligned_o    <= 1'b0;
        end else begin
            wb_valid_o   <= 1'b0;
            misaligned_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        if (!is_mem || misaligned) begin
                            wb_valid_o      <= 1'b1;
                            misaligned_o    <= is_mem;
                            wb_rd_addr_o    <= is_mem ? 5'd0 : rd_addr_i;
                            wb_result_src_o <= result_src_i;
                            wb_alu_result_o <= alu_result_i;
                            wb_mem_rdata_o  <= '0;
                            wb_pc_o         <= pc_i;
                        end else begin
                            state        <= REQ;
                            l_store      <= mem_write_i;
                            l_funct3     <= funct3_i;
                            l_alu        <= alu_result_i;
                            l_pc         <= pc_i;
                            l_rd         <= rd_addr_i;
                            l_src        <= result_src_i;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= mem_write_i;
                            dmem_addr_o  <= {alu_result_i[ADDR_WIDTH-1:2], 2'b00};
                            dmem_be_o    <= be_in;
                            dmem_wdata_o <= wdata_lanes;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (dmem_rvalid_i) begin
                        state           <= IDLE;
                        wb_valid_o      <= 1'b1;
                        wb_rd_addr_o    <= l_rd;
                        wb_result_src_o <= l_src;
                        wb_alu_result_o <= l_alu;
                        wb_mem_rdata_o  <= l_store ? '0 : load_data;
                        wb_pc_o         <= l_pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector table for single transactions plus
// hand sequences for back-to-back issue, held req_valid and reset mid-response.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  rd_addr = '0;
    logic [1:0]  result_src = '0;
    logic [31:0] pc = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [1:0]  wb_result_src;
    logic [31:0] wb_alu_result, wb_mem_rdata, wb_pc;
    logic        misaligned;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .funct3_i(funct3),
        .alu_result_i(alu_result), .wdata_i(wdata), .rd_addr_i(rd_addr),
        .result_src_i(result_src), .pc_i(pc),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
        .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
        .wb_valid_o(wb_valid), .wb_rd_addr_o(wb_rd_addr), .wb_result_src_o(wb_result_src),
        .wb_alu_result_o(wb_alu_result), .wb_mem_rdata_o(wb_mem_rdata), .wb_pc_o(wb_pc),
        .misaligned_o(misaligned)
    );

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pcv;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] rdata;
        int unsigned waits;
        logic        exp_bus;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input logic [1:0] s,
                         input logic [31:0] p);
        mem_read = r; mem_write = w; funct3 = f; alu_result = a;
        wdata = d; rd_addr = rd; result_src = s; pc = p;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        drive(v.rd_en, v.wr_en, v.f3, v.alu, v.wd, v.rd, v.src, v.pcv);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (v.exp_bus) begin
            check({tag, "_req"}, 32'(dmem_req), 32'd1);
            check({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
            check({tag, "_addr"}, dmem_addr, v.exp_addr);
            check({tag, "_be"}, 32'(dmem_be), 32'(v.exp_be));
            check({tag, "_we"}, 32'(dmem_we), 32'(v.wr_en));
            if (v.wr_en) check({tag, "_wdata"}, dmem_wdata, v.exp_wdata);
            for (int i = 0; i < int'(v.waits); i++) begin
                @(negedge clk);
                check({tag, "_req_hold"}, 32'(dmem_req), 32'd1);
                check({tag, "_addr_hold"}, dmem_addr, v.exp_addr);
            end
            dmem_gnt = 1'b1;
            @(negedge clk);
            dmem_gnt = 1'b0;
            check({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
            check({tag, "_wb_early"}, 32'(wb_valid), 32'd0);
            dmem_rvalid = 1'b1;
            dmem_rdata  = v.rdata;
            @(negedge clk);
            dmem_rvalid = 1'b0;
        end else begin
            check({tag, "_noreq"}, 32'(dmem_req), 32'd0);
        end
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, "_mis"}, 32'(misaligned), 32'(v.exp_mis));
        check({tag, "_wb_rd"}, 32'(wb_rd_addr), v.exp_mis ? 32'd0 : 32'(v.rd));
        check({tag, "_wb_src"}, 32'(wb_result_src), 32'(v.src));
        check({tag, "_wb_alu"}, wb_alu_result, v.alu);
        check({tag, "_wb_pc"}, wb_pc, v.pcv);
        check({tag, "_wb_rdata"}, wb_mem_rdata, v.exp_rdata);
        @(negedge clk);
        check({tag, "_wb_pulse"}, 32'(wb_valid), 32'd0);
        check({tag, "_wb_hold"}, wb_pc, v.pcv);
    endtask

    initial begin
        //          rd   wr   f3      alu           wdata         pc          rd    src    rdata         w  bus  addr          be       exp_wdata     exp_rdata     mis
        vecs[0]  = '{1'b0,1'b0,3'b000,32'h0000_1234,32'h0,        32'h100,    5'd5, 2'd0,  32'h0,        0, 1'b0,32'h0,        4'b0000, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b1,1'b0,3'b000,32'h0000_1003,32'h0,        32'h104,    5'd7, 2'd1,  32'h80FF_FF00,2, 1'b1,32'h0000_1000,4'b1000, 32'h0,        32'hFFFF_FF80,1'b0};
        vecs[2]  = '{1'b1,1'b0,3'b100,32'h0000_1003,32'h0,        32'h108,    5'd8, 2'd1,  32'h80FF_FF00,0, 1'b1,32'h0000_1000,4'b1000, 32'h0,        32'h0000_0080,1'b0};
        vecs[3]  = '{1'b0,1'b1,3'b001,32'h0000_2002,32'h0000_ABCD,32'h10C,    5'd9, 2'd0,  32'hDEAD_BEEF,1, 1'b1,32'h0000_2000,4'b1100, 32'hABCD_ABCD,32'h0,        1'b0};
        vecs[4]  = '{1'b1,1'b0,3'b010,32'h0000_3001,32'h0,        32'h110,    5'd10,2'd1,  32'h0,        0, 1'b0,32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[5]  = '{1'b1,1'b0,3'b001,32'h0000_4001,32'h0,        32'h114,    5'd11,2'd1,  32'h0,        0, 1'b0,32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[6]  = '{1'b1,1'b0,3'b101,32'h0000_4002,32'h0,        32'h118,    5'd12,2'd1,  32'h8001_0000,0, 1'b1,32'h0000_4000,4'b1100, 32'h0,        32'h0000_8001,1'b0};
        vecs[7]  = '{1'b1,1'b0,3'b001,32'h0000_4002,32'h0,        32'h11C,    5'd13,2'd1,  32'h8001_0000,0, 1'b1,32'h0000_4000,4'b1100, 32'h0,        32'hFFFF_8001,1'b0};
        vecs[8]  = '{1'b1,1'b0,3'b010,32'h0000_5000,32'h0,        32'h120,    5'd14,2'd1,  32'h1234_5678,3, 1'b1,32'h0000_5000,4'b1111, 32'h0,        32'h1234_5678,1'b0};
        vecs[9]  = '{1'b0,1'b1,3'b000,32'h0000_6001,32'h0000_00A5,32'h124,    5'd15,2'd0,  32'h0,        0, 1'b1,32'h0000_6000,4'b0010, 32'hA5A5_A5A5,32'h0,        1'b0};
        vecs[10] = '{1'b0,1'b1,3'b010,32'h0000_7000,32'hCAFE_BABE,32'h128,    5'd16,2'd0,  32'h0,        0, 1'b1,32'h0000_7000,4'b1111, 32'hCAFE_BABE,32'h0,        1'b0};
        vecs[11] = '{1'b1,1'b0,3'b011,32'h0000_8004,32'h0,        32'h12C,    5'd17,2'd1,  32'h1122_3344,0, 1'b1,32'h0000_8004,4'b1111, 32'h0,        32'h1122_3344,1'b0};
        vecs[12] = '{1'b1,1'b0,3'b111,32'h0000_8002,32'h0,        32'h130,    5'd18,2'd1,  32'h0,        0, 1'b0,32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[13] = '{1'b1,1'b1,3'b010,32'h0000_9000,32'h0000_0055,32'h134,    5'd19,2'd2,  32'hFFFF_FFFF,0, 1'b1,32'h0000_9000,4'b1111, 32'h0000_0055,32'h0,        1'b0};
        vecs[14] = '{1'b1,1'b0,3'b000,32'h0000_1001,32'h0,        32'h138,    5'd20,2'd1,  32'h0000_7F00,0, 1'b1,32'h0000_1000,4'b0010, 32'h0,        32'h0000_007F,1'b0};
        vecs[15] = '{1'b0,1'b1,3'b010,32'h0000_A002,32'h1111_2222,32'h13C,    5'd21,2'd0,  32'h0,        0, 1'b0,32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_pc", wb_pc, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-to-back ALU ops: one write-back per cycle
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 2'd0, 32'h100);
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_ready", 32'(req_ready), 32'd1);
            check("b2b_wb_valid", 32'(wb_valid), 32'd1);
            check("b2b_wb_rd", 32'(wb_rd_addr), 32'd5);
            check("b2b_wb_pc", wb_pc, 32'h100);
            check("b2b_wb_alu", wb_alu_result, 32'h1234);
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_pulse_end", 32'(wb_valid), 32'd0);

        // LHU with req_valid held: next instruction waits until IDLE
        drive(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0, 5'd3, 2'd1, 32'h300);
        req_valid = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0000_0077, 32'h0, 5'd9, 2'd0, 32'h200);
        check("hold_req", 32'(dmem_req), 32'd1);
        check("hold_ready_req", 32'(req_ready), 32'd0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("hold_ready_resp", 32'(req_ready), 32'd0);
        check("hold_no_wb", 32'(wb_valid), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h8001_0000;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("hold_lhu_valid", 32'(wb_valid), 32'd1);
        check("hold_lhu_rdata", wb_mem_rdata, 32'h0000_8001);
        check("hold_lhu_rd", 32'(wb_rd_addr), 32'd3);
        check("hold_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("hold_next_valid", 32'(wb_valid), 32'd1);
        check("hold_next_rd", 32'(wb_rd_addr), 32'd9);
        check("hold_next_pc", wb_pc, 32'h200);
        check("hold_next_rdata", wb_mem_rdata, 32'd0);
        @(negedge clk);
        check("hold_no_reissue", 32'(wb_valid), 32'd0);

        // Reset while waiting for a granted response; late rvalid is ignored
        drive(1'b1, 1'b0, 3'b010, 32'h0000_B000, 32'h0, 5'd4, 2'd1, 32'h400);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("rresp_ready_before", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rresp_ready", 32'(req_ready), 32'd1);
        check("rresp_req", 32'(dmem_req), 32'd0);
        check("rresp_addr", dmem_addr, 32'd0);
        check("rresp_wb_pc", wb_pc, 32'd0);
        check("rresp_wb_rd", 32'(wb_rd_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("rresp_late_rvalid", 32'(wb_valid), 32'd0);
        check("rresp_late_rdata", wb_mem_rdata, 32'd0);
        check("rresp_ready_after", 32'(req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
